// File: rtl/pulse_window_capture.sv
// Recovers (lower, upper) counter bounds from an active-low window waveform and reports them over valid/ready.
// Optional macro PULSE_WINDOW_SYNC_EN adds a 2-flop synchronizer on sig_in and widens the bound offset to match.
//
// state        | meaning
// S_IDLE       | after reset, waiting for the first period_start
// S_SEEK_FALL  | period running, waiting for the window to open
// S_SEEK_RISE  | lower latched, waiting for the window to close
// S_DONE       | pair captured for this period, waiting for period_start
module pulse_window_capture #(
  parameter int CW         = 32,
  parameter int LOCK_COUNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] counter,
  input  logic          period_start,
  input  logic          sig_in,
  output logic [CW-1:0] cap_lower,
  output logic [CW-1:0] cap_upper,
  output logic          cap_valid,
  input  logic          cap_ready,
  output logic          lock,
  output logic          mismatch,
  output logic          overrun,
  output logic          wrap_err
);

  typedef enum logic [1:0] {S_IDLE, S_SEEK_FALL, S_SEEK_RISE, S_DONE} state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);

  state_t        state, state_next;
  logic          sig_eff;
  logic          sig_prev;
  logic [CW-1:0] counter_d;
  logic [CW-1:0] edge_val;
  logic [CW-1:0] lower_q;
  logic [CW-1:0] prev_lower;
  logic [CW-1:0] prev_upper;
  logic          have_prev;
  logic [7:0]    stable_cnt;
  logic [7:0]    stable_next;
  logic          same_pair;
  logic          fall, rise;
  logic          latch_lower, complete, wrap_hit, stable_clr;

`ifdef PULSE_WINDOW_SYNC_EN
  // Two extra cycles of input latency, so the counter is two further ahead at the edge.
  localparam logic [CW-1:0] OFFSET = CW'(3);
  logic sync_1, sync_2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= sig_in;
      sync_2 <= sync_1;
    end
  end

  assign sig_eff = sync_2;
`else
  localparam logic [CW-1:0] OFFSET = CW'(1);

  assign sig_eff = sig_in;
`endif

  assign fall     = sig_prev & ~sig_eff;
  assign rise     = ~sig_prev & sig_eff;
  assign edge_val = counter_d - OFFSET;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Edge is evaluated against the current state first; period_start then overrides the destination.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (period_start) state_next = S_SEEK_FALL;
      S_SEEK_FALL: begin
        if (period_start)  state_next = S_SEEK_FALL;
        else if (fall)     state_next = S_SEEK_RISE;
      end
      S_SEEK_RISE: begin
        if (period_start)  state_next = S_SEEK_FALL;
        else if (rise)     state_next = S_DONE;
      end
      S_DONE:      if (period_start) state_next = S_SEEK_FALL;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    latch_lower = (state == S_SEEK_FALL) && fall;
    complete    = (state == S_SEEK_RISE) && rise;
    wrap_hit    = period_start &&
                  (((state == S_SEEK_RISE) && !rise) || ((state == S_SEEK_FALL) && fall));
    stable_clr  = period_start &&
                  ((state == S_SEEK_FALL) || ((state == S_SEEK_RISE) && !rise));
  end

  always_comb begin
    same_pair   = have_prev && (prev_lower == lower_q) && (prev_upper == edge_val);
    stable_next = 8'd1;
    if (same_pair) stable_next = (stable_cnt >= LOCK_N) ? LOCK_N : stable_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_d  <= '0;
      sig_prev   <= 1'b1;
      lower_q    <= '0;
      prev_lower <= '0;
      prev_upper <= '0;
      have_prev  <= 1'b0;
      stable_cnt <= '0;
      cap_lower  <= '0;
      cap_upper  <= '0;
      cap_valid  <= 1'b0;
      lock       <= 1'b0;
      mismatch   <= 1'b0;
      overrun    <= 1'b0;
      wrap_err   <= 1'b0;
    end else begin
      counter_d <= counter;
      sig_prev  <= sig_eff;
      mismatch  <= 1'b0;
      wrap_err  <= wrap_hit;
      if (latch_lower) lower_q <= edge_val;
      if (complete) begin
        if (!cap_valid || cap_ready) begin
          cap_lower <= lower_q;
          cap_upper <= edge_val;
          cap_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
        // History tracks every completed capture, even ones the consumer never saw.
        prev_lower <= lower_q;
        prev_upper <= edge_val;
        have_prev  <= 1'b1;
        stable_cnt <= stable_next;
        lock       <= (stable_next >= LOCK_N);
        mismatch   <= have_prev && !same_pair;
      end else begin
        if (cap_valid && cap_ready) cap_valid <= 1'b0;
        if (stable_clr) begin
          stable_cnt <= '0;
          lock       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_window_capture.sv
// Directed and randomized checks of pulse_window_capture against a period-level model of the generator and lock rules.
module tb_pulse_window_capture;

  localparam int LOCK = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] counter = 32'd63;
  logic        period_start = 1'b0;
  logic        sig_in = 1'b1;
  logic [31:0] cap_lower, cap_upper;
  logic        cap_valid;
  logic        cap_ready = 1'b1;
  logic        lock, mismatch, overrun, wrap_err;

  pulse_window_capture #(.CW(32), .LOCK_COUNT(LOCK)) dut (
    .clk(clk), .reset(reset), .counter(counter), .period_start(period_start),
    .sig_in(sig_in), .cap_lower(cap_lower), .cap_upper(cap_upper),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .lock(lock),
    .mismatch(mismatch), .overrun(overrun), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // generator programming and previous counter value (what the DUT holds as counter_d)
  logic [31:0] g_lo, g_hi;
  logic [31:0] cnt_prev = 32'd63;

  // per-period observations
  int n_valid, n_mm, n_wrap;
  logic [31:0] last_l, last_u;

  // lock/mismatch model
  bit          m_have;
  logic [31:0] m_l, m_u;
  int          m_stable;
  bit          m_lock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Window is low while (counter_d - 1) lies in [lower, upper), wrapping when lower > upper.
  function automatic bit in_win(input logic [31:0] v);
    if (g_lo <= g_hi) return (v >= g_lo) && (v < g_hi);
    return (v >= g_lo) || (v < g_hi);
  endfunction

  task automatic model_reset();
    m_have = 0; m_l = 0; m_u = 0; m_stable = 0; m_lock = 0;
  endtask

  task automatic model_capture(input logic [31:0] l, input logic [31:0] u, output int mm);
    mm = (m_have && (l != m_l || u != m_u)) ? 1 : 0;
    if (m_have && mm == 0) m_stable = (m_stable >= LOCK) ? LOCK : m_stable + 1;
    else m_stable = 1;
    m_have = 1; m_l = l; m_u = u;
    m_lock = (m_stable >= LOCK);
  endtask

  task automatic clear_stats();
    n_valid = 0; n_mm = 0; n_wrap = 0; last_l = 'x; last_u = 'x;
  endtask

  task automatic step(input int c);
    counter      = 32'(c);
    period_start = (c == 0);
    sig_in       = !in_win(cnt_prev - 32'd1);
    @(posedge clk); #1;
    cnt_prev = 32'(c);
    if (cap_valid) begin n_valid++; last_l = cap_lower; last_u = cap_upper; end
    if (mismatch) n_mm++;
    if (wrap_err) n_wrap++;
  endtask

  task automatic run_cycles(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) step(c);
  endtask

  task automatic run_period();
    clear_stats();
    run_cycles(0, 63);
  endtask

  task automatic check_period(input string tag, input int exp_n, input logic [31:0] l,
                              input logic [31:0] u, input int exp_mm, input int exp_wrap);
    chk({tag, ".valid_cycles"}, 32'(n_valid), 32'(exp_n));
    if (exp_n > 0) begin
      chk({tag, ".lower"}, last_l, l);
      chk({tag, ".upper"}, last_u, u);
    end
    chk({tag, ".mismatch"}, 32'(n_mm), 32'(exp_mm));
    chk({tag, ".wrap_err"}, 32'(n_wrap), 32'(exp_wrap));
    chk({tag, ".lock"}, 32'(lock), 32'(m_lock));
  endtask

  task automatic do_reset();
    reset = 1'b1; counter = 32'd63; period_start = 1'b0; sig_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    cnt_prev = 32'd63;
    model_reset();
  endtask

  // complete a capture for the currently programmed bounds and check the period
  task automatic normal_period(input string tag);
    int mm;
    run_period();
    model_capture(g_lo, g_hi, mm);
    check_period(tag, 1, g_lo, g_hi, mm, 0);
  endtask

  initial begin
    int mm;
    int reps;
    g_lo = 32'd10; g_hi = 32'd20;
    do_reset();
    chk("reset.cap_valid", 32'(cap_valid), 0);
    chk("reset.cap_lower", cap_lower, 0);
    chk("reset.cap_upper", cap_upper, 0);
    chk("reset.lock", 32'(lock), 0);
    chk("reset.overrun", 32'(overrun), 0);
    chk("reset.mismatch", 32'(mismatch), 0);
    chk("reset.wrap_err", 32'(wrap_err), 0);

    // basic capture and lock
    for (int p = 0; p < 5; p++) normal_period($sformatf("basic%0d", p));

    // change upper bound: mismatch, unlock, relock
    g_hi = 32'd25;
    for (int p = 0; p < 4; p++) normal_period($sformatf("chg%0d", p));

    // consumer stalls over two periods
    cap_ready = 1'b0;
    run_period();
    model_capture(g_lo, g_hi, mm);
    chk("stall1.cap_valid", 32'(cap_valid), 1);
    chk("stall1.cap_lower", cap_lower, 32'd10);
    chk("stall1.cap_upper", cap_upper, 32'd25);
    chk("stall1.overrun", 32'(overrun), 0);
    g_lo = 32'd12; g_hi = 32'd30;
    run_period();
    model_capture(g_lo, g_hi, mm);
    chk("stall2.cap_valid", 32'(cap_valid), 1);
    chk("stall2.cap_lower", cap_lower, 32'd10);
    chk("stall2.cap_upper", cap_upper, 32'd25);
    chk("stall2.overrun", 32'(overrun), 1);
    chk("stall2.mismatch", 32'(n_mm), 32'(mm));
    chk("stall2.lock", 32'(lock), 32'(m_lock));
    cap_ready = 1'b1;
    clear_stats();
    step(0);
    chk("drain.cap_valid", 32'(cap_valid), 0);
    clear_stats();
    run_cycles(1, 63);
    model_capture(g_lo, g_hi, mm);
    check_period("drain", 1, g_lo, g_hi, mm, 0);
    chk("drain.overrun_sticky", 32'(overrun), 1);

    // window spanning the period wrap never completes
    g_lo = 32'd60; g_hi = 32'd3;
    do_reset();
    chk("wrapreset.overrun", 32'(overrun), 0);
    run_period();
    check_period("wrap0", 0, 0, 0, 0, 0);
    for (int p = 1; p < 4; p++) begin
      run_period();
      check_period($sformatf("wrap%0d", p), 0, 0, 0, 0, 1);
    end

    // lower bound at all-ones, then reset in the middle of the window
    g_lo = 32'hFFFF_FFFF; g_hi = 32'd2;
    do_reset();
    cap_ready = 1'b0;
    run_period();
    chk("ones.cap_valid", 32'(cap_valid), 1);
    chk("ones.cap_lower", cap_lower, 32'hFFFF_FFFF);
    chk("ones.cap_upper", cap_upper, 32'd2);
    clear_stats();
    run_cycles(0, 2);
    reset = 1'b1;
    #1;
    chk("midreset.cap_valid", 32'(cap_valid), 0);
    chk("midreset.cap_lower", cap_lower, 0);
    chk("midreset.cap_upper", cap_upper, 0);
    chk("midreset.lock", 32'(lock), 0);
    chk("midreset.overrun", 32'(overrun), 0);
    #1 reset = 1'b0;
    model_reset();
    cap_ready = 1'b1;
    clear_stats();
    run_cycles(3, 63);
    check_period("postreset", 0, 0, 0, 0, 0);
    normal_period("ones_recap");

    // rise edge coincides with period_start
    g_lo = 32'd40; g_hi = 32'd62;
    do_reset();
    run_period();
    check_period("coin0", 0, 0, 0, 0, 0);
    for (int p = 1; p < 6; p++) normal_period($sformatf("coin%0d", p));

    // randomized bounds with random repeat counts
    g_lo = 32'd5; g_hi = 32'd6;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      g_lo = 32'($urandom_range(0, 50));
      g_hi = 32'($urandom_range(int'(g_lo) + 1, 61));
      reps = $urandom_range(1, 5);
      for (int r = 0; r < reps; r++) normal_period($sformatf("rnd%0d_%0d", k, r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
